sram_access_ctrl: RTL and testbench

Multi-cycle memory-stage controller between the EX/MEM pipeline register and an external 16-bit asynchronous SRAM. It turns each single-cycle 32-bit load or store request from the memory stage into two sequenced 16-bit SRAM accesses with programmable wait states. While an access is in progress it holds `ready` low, and the pipeline registers stall on that signal. On loads it returns the assembled 32-bit word to the memory stage.

---
 rtl/sram_access_ctrl.sv | 145 ++++++++++++++
 tb/tb_sram_access_ctrl.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/sram_access_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : sram_access_ctrl
//  Description : Memory-stage controller for a 16-bit asynchronous SRAM.
//                Splits each 32-bit load/store from EX/MEM into two 16-bit
//                SRAM accesses (low half, then high half), each held on the
//                bus for WAIT_CYCLES cycles, and stalls the pipeline through
//                `ready` while the access is in progress.
//  Ports       : clk, rst          - clock, asynchronous active-high reset
//                rd_en, wr_en      - load / store request (store wins)
//                address           - byte address of the 32-bit word
//                write_data        - store data
//                read_data         - last completed load word
//                ready             - 0 freezes the pipeline
//                sram_addr         - SRAM half-word address
//                sram_dq_out/_oe   - pad write data and output enable
//                sram_dq_in        - pad read data
//                sram_we_n         - active-low write strobe
//  Revision    : 1.0 - initial release
// ============================================================================
module sram_access_ctrl #(
    parameter logic [31:0] BASE_ADDR   = 32'd1024,
    parameter int          ADDR_W      = 18,
    parameter int          WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rd_en,
    input  logic              wr_en,
    input  logic [31:0]       address,
    input  logic [31:0]       write_data,
    output logic [31:0]       read_data,
    output logic              ready,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [15:0]       sram_dq_out,
    output logic              sram_dq_oe,
    input  logic [15:0]       sram_dq_in,
    output logic              sram_we_n
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_LO   = 2'd1;
    localparam logic [1:0] c_HI   = 2'd2;
    localparam logic [1:0] c_DONE = 2'd3;

    localparam logic [3:0] c_LAST = 4'(WAIT_CYCLES - 1);

    logic [1:0]  r_state;
    logic [3:0]  r_cnt;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic        r_is_wr;
    logic [15:0] r_lo;
    logic [31:0] r_rdata;

    logic        w_req;
    logic        w_last;
    logic        w_busy;
    logic        w_half;
    logic [31:0] w_offset;
    logic        w_unused;

    assign w_req    = rd_en | wr_en;
    assign w_last   = (r_cnt == c_LAST);
    assign w_busy   = (r_state == c_LO) || (r_state == c_HI);
    assign w_half   = (r_state == c_HI);
    // Byte offset into the SRAM; bits above ADDR_W drop out so the map wraps.
    assign w_offset = r_addr - BASE_ADDR;
    // Byte-lane bits and wrapped-away upper bits are intentionally ignored.
    assign w_unused = ^{w_offset[31:ADDR_W+1], w_offset[1:0]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_IDLE;
            r_cnt   <= 4'd0;
            r_addr  <= 32'd0;
            r_wdata <= 32'd0;
            r_is_wr <= 1'b0;
            r_lo    <= 16'd0;
            r_rdata <= 32'd0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_req) begin
                        r_addr  <= address;
                        r_wdata <= write_data;
                        r_is_wr <= wr_en;
                        r_cnt   <= 4'd0;
                        r_state <= c_LO;
                    end
                end
                c_LO: begin
                    if (w_last) begin
                        r_cnt   <= 4'd0;
                        r_state <= c_HI;
                        if (!r_is_wr) begin
                            r_lo <= sram_dq_in;
                        end
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                c_HI: begin
                    if (w_last) begin
                        r_cnt   <= 4'd0;
                        r_state <= c_DONE;
                        // read_data only changes once the full word is in hand.
                        if (!r_is_wr) begin
                            r_rdata <= {sram_dq_in, r_lo};
                        end
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                // Requests seen in DONE belong to the finishing instruction.
                c_DONE:  r_state <= c_IDLE;
                default: r_state <= c_IDLE;
            endcase
        end
    end

    always_comb begin
        sram_addr   = '0;
        sram_dq_out = 16'd0;
        sram_dq_oe  = 1'b0;
        sram_we_n   = 1'b1;
        if (w_busy) begin
            sram_addr = {w_offset[ADDR_W:2], w_half};
            if (r_is_wr) begin
                sram_dq_oe  = 1'b1;
                sram_we_n   = 1'b0;
                sram_dq_out = w_half ? r_wdata[31:16] : r_wdata[15:0];
            end
        end
    end

    // Reset holds ready high so the pipeline is never frozen during reset.
    assign ready = rst
                 | (r_state == c_DONE)
                 | ((r_state == c_IDLE) & ~w_req);

    assign read_data = r_rdata;

endmodule
`default_nettype wire

// File: tb/tb_sram_access_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sram_access_ctrl
//  Description : Self-checking bench for sram_access_ctrl. A 16-bit SRAM
//                model sits on the pads; a word-level reference memory and
//                the documented access timeline predict every output.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sram_access_ctrl;

    localparam int          W    = 2;
    localparam int          AW   = 18;
    localparam logic [31:0] BASE = 32'd1024;

    logic          clk;
    logic          rst;
    logic          rd_en;
    logic          wr_en;
    logic [31:0]   address;
    logic [31:0]   write_data;
    logic [31:0]   read_data;
    logic          ready;
    logic [AW-1:0] sram_addr;
    logic [15:0]   sram_dq_out;
    logic          sram_dq_oe;
    logic [15:0]   sram_dq_in;
    logic          sram_we_n;

    sram_access_ctrl #(
        .BASE_ADDR   (BASE),
        .ADDR_W      (AW),
        .WAIT_CYCLES (W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rd_en       (rd_en),
        .wr_en       (wr_en),
        .address     (address),
        .write_data  (write_data),
        .read_data   (read_data),
        .ready       (ready),
        .sram_addr   (sram_addr),
        .sram_dq_out (sram_dq_out),
        .sram_dq_oe  (sram_dq_oe),
        .sram_dq_in  (sram_dq_in),
        .sram_we_n   (sram_we_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Asynchronous SRAM pad model.
    logic [15:0] mem [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (!sram_we_n) mem[sram_addr] <= sram_dq_out;
    end
    assign sram_dq_in = sram_dq_oe ? 16'h0000 : mem[sram_addr];

    // Word-level reference memory, indexed by SRAM word number.
    logic [31:0] ref_mem [int unsigned];
    logic [31:0] exp_rd;
    int          n_vec;
    int          n_err;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int unsigned word_of(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE;
        return (off >> 2) % (32'd1 << (AW - 1));
    endfunction

    task automatic idle_cycle();
        rd_en = 1'b0;
        wr_en = 1'b0;
        @(negedge clk);
        chk("idle_ready", ready, 1);
        chk("idle_we_n", sram_we_n, 1);
        chk("idle_oe", sram_dq_oe, 0);
        chk("idle_addr", sram_addr, 0);
        chk("idle_rdata", read_data, exp_rd);
        @(posedge clk); #1;
    endtask

    // One access following the documented timeline: cycle 0 is the IDLE
    // cycle where the request is first seen, 1..W low half, W+1..2W high
    // half, 2W+1 DONE. The request is held throughout, as a stalled
    // pipeline would. abort_at >= 0 asserts reset in that cycle instead.
    task automatic do_access(input logic rd, input logic wr, input logic [31:0] a,
                             input logic [31:0] d, input int abort_at);
        int unsigned widx;
        logic        st;
        logic [31:0] new_rd;
        int          half;
        widx   = word_of(a);
        st     = wr;
        new_rd = exp_rd;
        if (!st) new_rd = ref_mem.exists(widx) ? ref_mem[widx] : 32'd0;
        rd_en      = rd;
        wr_en      = wr;
        address    = a;
        write_data = d;
        for (int k = 0; k <= 2*W+1; k++) begin
            if (k == abort_at) begin
                rst = 1'b1;
                #1;
                chk("rst_ready", ready, 1);
                chk("rst_we_n", sram_we_n, 1);
                chk("rst_oe", sram_dq_oe, 0);
                chk("rst_addr", sram_addr, 0);
                chk("rst_rdata", read_data, 0);
                exp_rd = 32'd0;
                rd_en  = 1'b0;
                wr_en  = 1'b0;
                @(posedge clk); #1;
                @(posedge clk); #1;
                rst = 1'b0;
                @(negedge clk);
                chk("post_rst_ready", ready, 1);
                chk("post_rst_rdata", read_data, 0);
                @(posedge clk); #1;
                return;
            end
            @(negedge clk);
            chk("ready", ready, (k == 2*W+1) ? 1 : 0);
            if (k >= 1 && k <= 2*W) begin
                half = (k > W) ? 1 : 0;
                chk("sram_addr", sram_addr, widx*2 + half);
                chk("we_n", sram_we_n, st ? 0 : 1);
                chk("oe", sram_dq_oe, st ? 1 : 0);
                if (st) chk("dq_out", sram_dq_out, half ? d[31:16] : d[15:0]);
            end else begin
                chk("we_n_off", sram_we_n, 1);
                chk("oe_off", sram_dq_oe, 0);
                chk("addr_off", sram_addr, 0);
            end
            chk("read_data", read_data, (k == 2*W+1) ? new_rd : exp_rd);
            @(posedge clk); #1;
        end
        exp_rd = new_rd;
        if (st) ref_mem[widx] = d;
        rd_en = 1'b0;
        wr_en = 1'b0;
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] d;
        logic        do_rd;
        logic        do_wr;
        n_vec      = 0;
        n_err      = 0;
        exp_rd     = 32'd0;
        rst        = 1'b1;
        rd_en      = 1'b0;
        wr_en      = 1'b0;
        address    = 32'd0;
        write_data = 32'd0;
        for (int i = 0; i < (1<<AW); i++) mem[i] = 16'h0000;

        #3;
        chk("reset_ready", ready, 1);
        chk("reset_rdata", read_data, 0);
        chk("reset_we_n", sram_we_n, 1);
        chk("reset_oe", sram_dq_oe, 0);
        chk("reset_addr", sram_addr, 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        idle_cycle();

        // Store, load-back, then back-to-back load and store.
        do_access(1'b0, 1'b1, 32'd1032, 32'hDEADBEEF, -1);
        idle_cycle();
        do_access(1'b1, 1'b0, 32'd1032, 32'h0, -1);
        chk("load_word", read_data, 32'hDEADBEEF);
        do_access(1'b0, 1'b1, 32'd1040, 32'h12345678, -1);
        chk("rdata_after_store", read_data, 32'hDEADBEEF);
        // Simultaneous request is a store.
        do_access(1'b1, 1'b1, 32'd1044, 32'hCAFEF00D, -1);
        chk("rdata_after_both", read_data, 32'hDEADBEEF);
        // Address wrap lands on SRAM word 2 (half-words 4/5).
        do_access(1'b0, 1'b1, BASE + (32'd1 << (AW+1)) + 32'd8, 32'hA5A55A5A, -1);
        do_access(1'b1, 1'b0, 32'd1032, 32'h0, -1);
        chk("wrap_word", read_data, 32'hA5A55A5A);
        // Reset during the high half of a load, then a normal access.
        do_access(1'b1, 1'b0, 32'd1040, 32'h0, W+1);
        do_access(1'b1, 1'b0, 32'd1040, 32'h0, -1);
        chk("after_abort", read_data, 32'h12345678);

        // Randomized traffic over a small address pool.
        for (int n = 0; n < 60; n++) begin
            a = BASE + 32'($urandom_range(0, 7) * 4) + 32'($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) a = a + (32'd1 << (AW+1));
            d = $urandom;
            do_rd = $urandom_range(0, 1);
            do_wr = !do_rd || ($urandom_range(0, 3) == 0);
            if (!do_wr && !ref_mem.exists(word_of(a))) do_wr = 1'b1;
            do_access(do_rd, do_wr, a, d, -1);
            for (int g = $urandom_range(0, 2); g > 0; g--) idle_cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
